// File: rtl/fifo_uart_tx_drain.sv
// Pops words from a first-word-fall-through FIFO and sends each one as a UART frame:
// start bit, data LSB first, optional parity, then stop bits. All outputs are flops.
module fifo_uart_tx_drain #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 empty,
  input  logic [DATA_SIZE-1:0] read_data_out,
  output logic                 read_from_fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           state_dbg
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_SIZE - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [3:0]           bit_idx, bit_n;
  logic [DATA_SIZE-1:0] shift, shift_n;
  logic                 par_bit, par_n;
  logic                 pop;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end, can_pop;

  assign bit_end   = (baud == BAUD_LAST);
  assign can_pop   = enable && !empty;
  assign state_dbg = state;

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      baud           <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      par_bit        <= 1'b0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      read_from_fifo <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_n;
      baud           <= baud_n;
      bit_idx        <= bit_n;
      shift          <= shift_n;
      par_bit        <= par_n;
      tx             <= tx_n;
      busy           <= busy_n;
      read_from_fifo <= pop;
      frame_done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (can_pop) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            bit_n = '0;
            // Chaining straight into START keeps the line gap-free between queued words.
            if (can_pop) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (pop) begin
      shift_n = read_data_out;
      par_n   = (^read_data_out) ^ ODD;
    end
  end

  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST) && (bit_n == STOP_LAST);
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: FIFO model, UART line decoder with an expected-word queue,
// and per-scenario tasks for timing, gating, reset and parity behaviour.
module tb_fifo_uart_tx_drain;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       empty;
  logic [7:0] read_data_out;
  logic       read_from_fifo, tx, busy, frame_done;
  logic [2:0] state_dbg;

  logic       enable_p = 1'b0;
  logic       empty_p = 1'b1;
  logic [7:0] data_p = 8'h07;
  logic       rff_p1, tx_p1, busy_p1, done_p1;
  logic       rff_p2, tx_p2, busy_p2, done_p2;
  logic [2:0] st_p1, st_p2;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  assign empty         = (fifo_q.size() == 0);
  assign read_data_out = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;

  fifo_uart_tx_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty), .read_data_out(read_data_out),
    .read_from_fifo(read_from_fifo), .tx(tx), .busy(busy), .frame_done(frame_done),
    .state_dbg(state_dbg));

  fifo_uart_tx_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .enable(enable_p), .empty(empty_p), .read_data_out(data_p),
    .read_from_fifo(rff_p1), .tx(tx_p1), .busy(busy_p1), .frame_done(done_p1),
    .state_dbg(st_p1));

  fifo_uart_tx_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .enable(enable_p), .empty(empty_p), .read_data_out(data_p),
    .read_from_fifo(rff_p2), .tx(tx_p2), .busy(busy_p2), .frame_done(done_p2),
    .state_dbg(st_p2));

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // FIFO model: the pop strobe removes the head word
  always @(negedge clk) begin
    if (reset === 1'b1 && read_from_fifo === 1'b1) begin
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL pop_on_empty: got read_from_fifo=1 with empty fifo, required 0");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
  end

  // Line decoder / scoreboard: samples each bit mid-way and compares against exp_q
  initial begin
    bit         active;
    int         cyc;
    logic [9:0] bits;
    logic [7:0] exp_w;
    active = 1'b0;
    cyc    = 0;
    bits   = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        active = 1'b0;
        continue;
      end
      if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cyc    = 0;
        end else begin
          continue;
        end
      end
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (read_from_fifo !== 1'b1) begin
          errors++;
          $display("FAIL pop_with_start: got read_from_fifo=%b, required 1", read_from_fifo);
        end
      end
      if (cyc % CPB == CPB / 2) bits[cyc / CPB] = tx;
      if (cyc == FRAME) begin
        checks++;
        if (frame_done !== 1'b1) begin
          errors++;
          $display("FAIL frame_done_last: got %b, required 1", frame_done);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_data: got frame %h, required no frame", bits);
        end else begin
          exp_w = exp_q.pop_front();
          if (bits !== {1'b1, exp_w, 1'b0}) begin
            errors++;
            $display("FAIL frame_data: got frame %h, required %h", bits, {1'b1, exp_w, 1'b0});
          end
        end
        active = 1'b0;
      end else if (frame_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL frame_done_early: got 1 at frame cycle %0d, required 0", cyc);
      end
    end
  end

  // Counts busy cycles and pops until busy falls (bounded)
  task automatic measure(output int busy_cycles, output int pops);
    busy_cycles = 0;
    pops        = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (read_from_fifo === 1'b1) pops++;
      if (busy === 1'b1) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, read_from_fifo, frame_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got tx/busy/rff/done=%b, required 1000",
               {tx, busy, read_from_fifo, frame_done});
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, required 0", state_dbg);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset: got tx/busy=%b, required 10", {tx, busy});
    end
  endtask

  task automatic test_single();
    int bc, pops;
    push_word(8'hA1);
    enable = 1'b1;
    measure(bc, pops);
    enable = 1'b0;
    checks++;
    if (bc != FRAME) begin
      errors++;
      $display("FAIL single_len: got %0d busy clks, required %0d", bc, FRAME);
    end
    checks++;
    if (pops != 1) begin
      errors++;
      $display("FAIL single_pops: got %0d, required 1", pops);
    end
    #1;
    checks++;
    if (fifo_q.size() != 0) begin
      errors++;
      $display("FAIL single_empty: got %0d words left, required 0", fifo_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int bc, pops;
    push_word(8'hFF);
    push_word(8'h01);
    enable = 1'b1;
    measure(bc, pops);
    enable = 1'b0;
    checks++;
    if (bc != 2 * FRAME) begin
      errors++;
      $display("FAIL b2b_busy: got %0d busy clks, required %0d", bc, 2 * FRAME);
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL b2b_pops: got %0d, required 2", pops);
    end
  endtask

  task automatic test_enable_gate();
    int bc, pops, bad;
    bad = 0;
    push_word(8'h3C);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || read_from_fifo !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gated_idle: got %0d active cycles, required 0", bad);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({read_from_fifo, tx} !== 2'b10) begin
      errors++;
      $display("FAIL enable_start: got rff/tx=%b, required 10", {read_from_fifo, tx});
    end
    measure(bc, pops);
    enable = 1'b0;
    checks++;
    if (bc != FRAME - 1 || pops != 0) begin
      errors++;
      $display("FAIL enable_frame: got %0d clks %0d pops, required %0d clks 0 pops", bc, pops, FRAME - 1);
    end
  endtask

  task automatic test_enable_drop();
    int bc, pops;
    push_word(8'h11);
    push_word(8'h22);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    measure(bc, pops);
    checks++;
    if (bc != FRAME - 10 || pops != 0) begin
      errors++;
      $display("FAIL drop_finish: got %0d clks %0d pops, required %0d clks 0 pops", bc, pops, FRAME - 10);
    end
    #1;
    checks++;
    if (fifo_q.size() != 1) begin
      errors++;
      $display("FAIL drop_no_pop: got %0d words left, required 1", fifo_q.size());
    end
    @(negedge clk);
    enable = 1'b1;
    measure(bc, pops);
    enable = 1'b0;
    checks++;
    if (bc != FRAME || pops != 1) begin
      errors++;
      $display("FAIL drop_resume: got %0d clks %0d pops, required %0d clks 1 pops", bc, pops, FRAME);
    end
  endtask

  task automatic test_reset_mid();
    int bc, pops, t, bad;
    push_word(8'h99);
    enable = 1'b1;
    t = 0;
    while (read_from_fifo !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (read_from_fifo !== 1'b1) begin
      errors++;
      $display("FAIL mid_start: got no pop within 20 clks, required a pop");
    end
    repeat (16) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tx, busy, read_from_fifo} !== 3'b100 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got tx/busy/rff=%b state=%0d, required 100 state=0",
               {tx, busy, read_from_fifo}, state_dbg);
    end
    void'(exp_q.pop_front());
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (read_from_fifo !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_hold: got %0d active cycles in reset, required 0", bad);
    end
    enable = 1'b0;
    push_word(8'h5A);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    measure(bc, pops);
    enable = 1'b0;
    checks++;
    if (bc != FRAME || pops != 1) begin
      errors++;
      $display("FAIL mid_recover: got %0d clks %0d pops, required %0d clks 1 pops", bc, pops, FRAME);
    end
  endtask

  task automatic test_empty_idle();
    int bad_tx, bad_pop;
    bad_tx  = 0;
    bad_pop = 0;
    enable  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (read_from_fifo !== 1'b0) bad_pop++;
    end
    enable = 1'b0;
    checks++;
    if (bad_tx != 0) begin
      errors++;
      $display("FAIL empty_tx: got %0d low cycles, required 0", bad_tx);
    end
    checks++;
    if (bad_pop != 0) begin
      errors++;
      $display("FAIL empty_pop: got %0d pops, required 0", bad_pop);
    end
  endtask

  task automatic test_parity();
    int bc, cyc;
    logic pe, po, de;
    pe = 1'bx;
    po = 1'bx;
    de = 1'b0;
    empty_p  = 1'b0;
    enable_p = 1'b1;
    @(negedge clk);
    empty_p  = 1'b1;
    enable_p = 1'b0;
    checks++;
    if ({rff_p1, rff_p2} !== 2'b11) begin
      errors++;
      $display("FAIL parity_pop: got %b, required 11", {rff_p1, rff_p2});
    end
    bc  = (busy_p1 === 1'b1) ? 1 : 0;
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 9 * CPB + CPB / 2) begin
        pe = tx_p1;
        po = tx_p2;
      end
      if (cyc == 11 * CPB) de = done_p1 & done_p2;
      if (busy_p1 === 1'b1) bc++;
      else break;
    end
    checks++;
    if (pe !== 1'b1) begin
      errors++;
      $display("FAIL parity_even: got %b, required 1", pe);
    end
    checks++;
    if (po !== 1'b0) begin
      errors++;
      $display("FAIL parity_odd: got %b, required 0", po);
    end
    checks++;
    if (bc != 11 * CPB || de !== 1'b1) begin
      errors++;
      $display("FAIL parity_len: got %0d clks done=%b, required %0d clks done=1", bc, de, 11 * CPB);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gate();
    test_enable_drop();
    test_reset_mid();
    test_empty_idle();
    test_parity();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing: got %0d undelivered words, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
